// File: rtl/fixed_point_neuron_mac.sv
// Streaming fixed-point MAC for one neuron pre-activation: bias + sum(x*w),
// saturated to DATA_WIDTH in Q(INTEGER).(FRACTION) format.
//
// state | meaning
// IDLE  | waiting for the first beat of a vector
// ACCUM | accepting further beats of the current vector
// DRAIN | last beat accepted; flush pending product, then saturate
// DONE  | result presented on out_*, waiting for out_ready
module fixed_point_neuron_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int INTEGER    = 10,
    parameter int FRACTION   = 22,
    parameter int ACC_WIDTH  = 48,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_w,
    input  logic [DATA_WIDTH-1:0] in_bias,
    input  logic                  in_act_enable,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_act_enable,
    output logic                  out_sat,
    output logic [LEN_WIDTH-1:0]  out_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [PW-1:0] ROUND_HALF = PW'(1) << (FRACTION - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                 state, state_next;
    logic                   accept;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   prod;
    logic                   prod_valid;
    logic [LEN_WIDTH-1:0]   count;
    logic                   act_cap;

    logic signed [PW-1:0]   prod_full;
    logic signed [PW-1:0]   prod_round;
    logic signed [PW-1:0]   prod_shift;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   bias_ext;
    logic                   overflow;
    logic [DATA_WIDTH-1:0]  sat_data;

    assign accept = in_valid & in_ready;

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = in_last ? DRAIN : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (!prod_valid) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Round-half-up product, sign-extended bias, and output saturation
    always_comb begin
        prod_full  = $signed(in_x) * $signed(in_w);
        prod_round = prod_full + $signed(ROUND_HALF);
        prod_shift = prod_round >>> FRACTION;
        // Shifted product fits in 2*DATA_WIDTH-FRACTION bits, so the low
        // ACC_WIDTH bits are already its sign extension.
        prod_ext   = prod_shift[ACC_WIDTH-1:0];
        bias_ext   = {{(ACC_WIDTH-DATA_WIDTH){in_bias[DATA_WIDTH-1]}}, in_bias};
        overflow   = !((&acc[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|acc[ACC_WIDTH-1:DATA_WIDTH-1]));
        sat_data   = acc[DATA_WIDTH-1:0];
        if (overflow) sat_data = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Product pipeline register and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod_valid <= accept;
            if (accept) prod <= prod_ext;
            if (accept && state == IDLE) acc <= bias_ext;
            else if (prod_valid)         acc <= acc + prod;
        end
    end

    // Term counter and first-beat activation-enable capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            act_cap <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                count   <= LEN_WIDTH'(1);
                act_cap <= in_act_enable;
            end else if (count != '1) begin
                count <= count + LEN_WIDTH'(1);
            end
        end
    end

    // Result registers, loaded once the last product has been folded in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data       <= '0;
            out_sat        <= 1'b0;
            out_count      <= '0;
            out_act_enable <= 1'b0;
        end else if (state == DRAIN && !prod_valid) begin
            out_data       <= sat_data;
            out_sat        <= overflow;
            out_count      <= count;
            out_act_enable <= act_cap;
        end
    end

endmodule

// File: tb/tb_fixed_point_neuron_mac.sv
// Directed bench for fixed_point_neuron_mac: table of vectors with
// hand-computed results plus backpressure and mid-vector reset sequences.
module tb_fixed_point_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_w;
    logic [31:0] in_bias;
    logic        in_act_enable;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_act_enable;
    logic        out_sat;
    logic [15:0] out_count;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0]      bias;
        logic             act;
        int               n;
        logic [3:0][31:0] x;
        logic [3:0][31:0] w;
        int               gap;
        logic [31:0]      exp_data;
        logic             exp_sat;
        int               exp_count;
    } vec_t;

    vec_t vecs[$];

    fixed_point_neuron_mac dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_bias(in_bias),
        .in_act_enable(in_act_enable), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_act_enable(out_act_enable),
        .out_sat(out_sat), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] bias, input logic act, input int n,
                                input logic [31:0] x0, input logic [31:0] w0,
                                input logic [31:0] x1, input logic [31:0] w1,
                                input logic [31:0] x2, input logic [31:0] w2,
                                input logic [31:0] x3, input logic [31:0] w3,
                                input int gap, input logic [31:0] exp_data,
                                input logic exp_sat, input int exp_count);
        vec_t v;
        v.bias = bias; v.act = act; v.n = n; v.gap = gap;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.exp_data = exp_data; v.exp_sat = exp_sat; v.exp_count = exp_count;
        return v;
    endfunction

    // Waits for out_valid after the last-accept edge; returns edges elapsed.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_last = 1'b0;
        in_x = '0; in_w = '0; in_bias = '0; in_act_enable = 1'b0;
    endtask

    task automatic send_beats(input vec_t v, input int nb);
        for (int b = 0; b < nb; b++) begin
            in_valid      = 1'b1;
            in_x          = v.x[b];
            in_w          = v.w[b];
            in_bias       = (b == 0) ? v.bias : 32'hDEAD_BEEF;
            in_act_enable = (b == 0) ? v.act : ~v.act;
            in_last       = (b == v.n - 1);
            tick();
            if (b != v.n - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    in_valid = 1'b0; in_last = 1'b1;
                    in_x = $urandom; in_w = $urandom; in_bias = $urandom;
                    tick();
                end
            end
        end
        drive_idle();
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        send_beats(v, v.n);
        wait_out(lat);
        chk({tag, " latency"}, 64'(lat), 64'd2);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out_data"}, 64'(out_data), 64'(v.exp_data));
        chk({tag, " out_sat"}, 64'(out_sat), 64'(v.exp_sat));
        chk({tag, " out_count"}, 64'(out_count), 64'(v.exp_count));
        chk({tag, " out_act_enable"}, 64'(out_act_enable), 64'(v.act));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " handoff"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        vec_t v;
        int lat;
        logic [31:0] held;

        vecs.push_back(mk(32'h0010_0000, 1'b1, 2, 32'h0040_0000, 32'h0020_0000,
                          32'h0020_0000, 32'h0080_0000, 0, 0, 0, 0, 0, 32'h0070_0000, 1'b0, 2));
        vecs.push_back(mk(32'h0, 1'b0, 4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                          32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0,
                          32'h7FFF_FFFF, 1'b1, 4));
        vecs.push_back(mk(32'h0, 1'b1, 4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                          32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 0,
                          32'h8000_0000, 1'b1, 4));
        vecs.push_back(mk(32'h0, 1'b0, 1, 32'h0000_0001, 32'h0020_0000, 0, 0, 0, 0, 0, 0, 0,
                          32'h0000_0001, 1'b0, 1));
        vecs.push_back(mk(32'h0, 1'b0, 1, 32'h0000_0001, 32'h001F_FFFF, 0, 0, 0, 0, 0, 0, 0,
                          32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(32'h0, 1'b1, 3, 32'h0040_0000, 32'h0040_0000, 32'h0020_0000, 32'h0020_0000,
                          32'h0080_0000, 32'hFFC0_0000, 0, 0, 0, 32'hFFD0_0000, 1'b0, 3));
        vecs.push_back(mk(32'h0, 1'b1, 3, 32'h0040_0000, 32'h0040_0000, 32'h0020_0000, 32'h0020_0000,
                          32'h0080_0000, 32'hFFC0_0000, 0, 0, 2, 32'hFFD0_0000, 1'b0, 3));
        vecs.push_back(mk(32'h0010_0000, 1'b1, 1, 32'h0080_0000, 32'h00C0_0000, 0, 0, 0, 0, 0, 0, 0,
                          32'h0190_0000, 1'b0, 1));
        vecs.push_back(mk(32'h0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0020_0000, 0, 0, 0, 0, 0, 0, 0,
                          32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(32'h7FF0_0000, 1'b1, 1, 32'h0004_0000, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0,
                          32'h7FF4_0000, 1'b0, 1));
        vecs.push_back(mk(32'h7FF0_0000, 1'b1, 1, 32'h0010_0000, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0,
                          32'h7FFF_FFFF, 1'b1, 1));

        drive_idle();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset outputs", {out_valid, out_sat, out_act_enable, out_count, out_data},
            64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: a follow-on beat is held on in_valid throughout DRAIN/DONE.
        send_beats(vecs[0], 2);
        in_valid = 1'b1; in_x = 32'h0040_0000; in_w = 32'h0040_0000;
        in_bias = 32'h0; in_act_enable = 1'b0; in_last = 1'b1;
        wait_out(lat);
        chk("bp latency", 64'(lat), 64'd2);
        held = out_data;
        chk("bp data", 64'(held), 64'h0070_0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp hold%0d", c),
                {out_valid, in_ready, out_count, out_data}, {1'b1, 1'b0, 16'd2, 32'h0070_0000});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp handoff", {62'd0, out_valid, in_ready}, 64'b01);
        tick();
        drive_idle();
        wait_out(lat);
        chk("bp next latency", 64'(lat), 64'd2);
        chk("bp next result", {out_count, out_data}, {16'd1, 32'h0040_0000});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset after 2 of 4 beats discards the vector.
        v = mk(32'h0, 1'b1, 4, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000,
               32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 0, 0, 1'b0, 4);
        send_beats(v, 2);
        rst_n = 1'b0;
        tick();
        chk("mid reset outputs", {out_valid, out_sat, out_act_enable, out_count, out_data},
            64'd0);
        rst_n = 1'b1;
        v = mk(32'h0, 1'b0, 1, 32'h0040_0000, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0,
               32'h0040_0000, 1'b0, 1);
        run_vec("post reset", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fixed_point_neuron_mac.md
Name: fixed_point_neuron_mac

Overview:
- Streaming fixed-point multiply-accumulate that computes one neuron pre-activation: sum of x[i]*w[i] over a vector, plus a bias.
- Output is the saturated DATA_WIDTH result in the same Q(INTEGER).(FRACTION) format. It feeds directly into the combinational sigmoid/tanh stage.
- It also carries a registered activation-enable bit that drives that stage's enable input.

Parameters:
- DATA_WIDTH, 32, width of x, w, bias and result words (two's complement).
- INTEGER, 10, integer bits including sign; INTEGER+FRACTION = DATA_WIDTH.
- FRACTION, 22, fraction bits.
- ACC_WIDTH, 48, accumulator width; must be >= 2*DATA_WIDTH-FRACTION.
- LEN_WIDTH, 16, width of the term counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  DATA_WIDTH  activation operand.
- in_w  in  DATA_WIDTH  weight operand.
- in_bias  in  DATA_WIDTH  bias; sampled only on the first beat of a vector.
- in_act_enable  in  1  activation enable; sampled only on the first beat.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  saturated result.
- out_act_enable  out  1  registered in_act_enable; drives the activation stage enable.
- out_sat  out  1  result was clamped.
- out_count  out  LEN_WIDTH  number of terms accumulated; saturates at all-ones.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE; the accumulator, product register, counter and all outputs are cleared to 0. This includes in-flight vectors, which are discarded.
- States:
  - IDLE: in_ready=1.
  - ACCUM: in_ready=1.
  - DRAIN: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- A beat is accepted when in_valid & in_ready. in_last, in_bias and in_act_enable are ignored while in_valid=0.
- IDLE, on accept:
  - Accumulator is loaded with sign-extended in_bias, shifted left 0.
  - in_act_enable is captured; counter is set to 1.
  - Next state is ACCUM, or DRAIN if in_last=1.
- ACCUM, on accept: counter increments (saturating). Next state stays ACCUM, or goes to DRAIN if in_last=1.
- Product path:
  - The full 2*DATA_WIDTH signed product is rounded half-up: add 2^(FRACTION-1), then arithmetic shift right by FRACTION.
  - The result is sign-extended to ACC_WIDTH and registered with its valid bit on the accept edge.
  - On the following edge it is added to the accumulator. The accumulator wraps modulo 2^ACC_WIDTH; there is no internal saturation.
  - The product register is updated and consumed on consecutive edges, so back-to-back beats run at one per cycle.
- DRAIN: on the next edge, the final sum (accumulator + pending product) is saturated to DATA_WIDTH.
  - Values above max clamp to 0x7FFF_FFFF; values below min clamp to 0x8000_0000; out_sat=1 when clamped.
  - The result is registered into out_data, out_act_enable and out_count; state goes to DONE.
- Latency: out_valid rises 2 edges after the edge that accepted the in_last beat.
- DONE: outputs stay stable while out_ready=0. On an edge with out_ready=1, out_valid falls and state goes to IDLE.
  - out_data, out_sat, out_count and out_act_enable hold their last values after the handoff; only out_valid qualifies them.
  - A new vector may be accepted starting the cycle after the handoff. There is no overlap of vectors.
- in_valid gaps mid-vector are allowed: the state holds and no term is added.
- When out_count reaches all-ones it stops incrementing; accumulation still proceeds.

Test Plan:
1. Basic dot product (1.0=0x0040_0000):
   - Stimulus: bias=0x0010_0000 (0.25); beats (x,w)=(0x0040_0000, 0x0020_0000), (0x0020_0000, 0x0080_0000) with last on beat 2, act_enable=1.
   - Required: out_data=0x0070_0000 (1.75), out_count=2, out_sat=0, out_act_enable=1, out_valid exactly 2 edges after the last accept.
2. Saturation:
   - 4 beats x=w=0x7FFF_FFFF, bias=0 -> out_data=0x7FFF_FFFF, out_sat=1.
   - 4 beats x=0x8000_0000, w=0x7FFF_FFFF -> out_data=0x8000_0000, out_sat=1.
3. Rounding:
   - Single beat x=0x0000_0001, w=0x0020_0000, bias=0 -> out_data=0x0000_0001.
   - Single beat x=0x0000_0001, w=0x001F_FFFF -> out_data=0x0000_0000.
4. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 continuously.
   - Required: out_data/out_valid stable, in_ready=0, no beats consumed. out_ready=1 -> IDLE; next vector starts the following cycle.
5. Gaps and single-beat vector:
   - 3-beat vector with in_valid=0 for 2 cycles between beats -> same result as gapless.
   - Single-beat vector (in_last on first beat) -> result=bias+x*w, out_count=1.
6. Reset mid-vector:
   - Stimulus: assert rst_n=0 for 1 edge after 2 of 4 beats, then send a new 1-beat vector x=w=0x0040_0000, bias=0.
   - Required: out_data=0x0040_0000, out_count=1; all outputs are 0 during reset.
